// File: rtl/icache_pkg.sv
// Shared constants, FSM encoding and word-select helper for the instruction cache.
// Optional statistics counters are enabled by defining ICACHE_STATS_EN.
package icache_pkg;

    localparam int WORD_SIZE         = 16;
    localparam int ICACHE_LINE_WORDS = 4;
    localparam int LINE_BITS         = WORD_SIZE * ICACHE_LINE_WORDS;
    localparam int ADDR_W            = 16;
    localparam int OFFSET_W          = 2;
    localparam int LINE_ADDR_W       = ADDR_W - OFFSET_W;
    localparam int CNT_W             = 16;

    typedef enum logic {
        ICACHE_IDLE = 1'b0,
        ICACHE_FILL = 1'b1
    } icache_state_e;

    // Word 0 sits in the least significant bits of a line.
    function automatic logic [WORD_SIZE-1:0] line_word(
        input logic [LINE_BITS-1:0] line,
        input logic [OFFSET_W-1:0]  offset
    );
        int sh;
        sh = int'(offset) * WORD_SIZE;
        return line[sh +: WORD_SIZE];
    endfunction

endpackage

// File: rtl/icache_if.sv
// CPU fetch port plus line-based memory port of the instruction cache.
// master = CPU/memory side, slave = cache side.
interface icache_if;
    import icache_pkg::*;

    logic                   i_readM;
    logic [ADDR_W-1:0]      i_address;
    logic [WORD_SIZE-1:0]   i_data;
    logic                   i_ready;

    logic                   m_readM;
    logic [ADDR_W-1:0]      m_address;
    logic [LINE_BITS-1:0]   m_data;
    logic                   m_valid;

    modport master (
        output i_readM, i_address, m_data, m_valid,
        input  i_data, i_ready, m_readM, m_address
    );

    modport slave (
        input  i_readM, i_address, m_data, m_valid,
        output i_data, i_ready, m_readM, m_address
    );

endinterface

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays for the direct-mapped cache: async read, sync write.
// Latency: read 0 cycles, write lands at the clock edge; only valid bits are reset.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int  NUM_LINES = 8,
    localparam int IDX_W     = $clog2(NUM_LINES),
    localparam int TAG_W     = LINE_ADDR_W - IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [LINE_BITS-1:0] wr_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data are only meaningful behind a set valid bit, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 0-cycle hits, whole-line fill on miss.
// CPU stalls via i_ready=0 during a fill; hit_count/miss_count exist only with ICACHE_STATS_EN.
module icache
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 8
) (
    input  logic            Clk,
    input  logic            Reset_N,
    icache_if.slave         bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = LINE_ADDR_W - IDX_W;

    icache_state_e          state_q, state_d;
    logic [LINE_ADDR_W-1:0] fill_line_q;
    logic                   hit;
    logic                   load_fill;
    logic                   wr_en;

    logic [OFFSET_W-1:0]    req_offset;
    logic [IDX_W-1:0]       req_idx;
    logic [TAG_W-1:0]       req_tag;
    logic [IDX_W-1:0]       fill_idx;
    logic [TAG_W-1:0]       fill_tag;

    logic                   rd_valid;
    logic [TAG_W-1:0]       rd_tag;
    logic [LINE_BITS-1:0]   rd_data;

    assign req_offset = bus.i_address[OFFSET_W-1:0];
    assign req_idx    = bus.i_address[OFFSET_W +: IDX_W];
    assign req_tag    = bus.i_address[ADDR_W-1 -: TAG_W];

    assign fill_idx   = fill_line_q[IDX_W-1:0];
    assign fill_tag   = fill_line_q[LINE_ADDR_W-1 -: TAG_W];

    icache_line_store #(
        .NUM_LINES (NUM_LINES)
    ) u_store (
        .clk      (Clk),
        .rst_n    (Reset_N),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (fill_idx),
        .wr_tag   (fill_tag),
        .wr_data  (bus.m_data)
    );

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q     <= ICACHE_IDLE;
            fill_line_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_fill) begin
                fill_line_q <= bus.i_address[ADDR_W-1:OFFSET_W];
            end
        end
    end

    // A fill always completes; lookup resumes on whatever the CPU presents afterwards.
    always_comb begin
        state_d   = state_q;
        hit       = 1'b0;
        load_fill = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            ICACHE_IDLE: begin
                hit = bus.i_readM & rd_valid & (rd_tag == req_tag);
                if (bus.i_readM && !hit) begin
                    load_fill = 1'b1;
                    state_d   = ICACHE_FILL;
                end
            end
            ICACHE_FILL: begin
                if (bus.m_valid) begin
                    wr_en   = 1'b1;
                    state_d = ICACHE_IDLE;
                end
            end
            default: state_d = ICACHE_IDLE;
        endcase
    end

    assign bus.i_ready   = hit;
    assign bus.i_data    = hit ? line_word(rd_data, req_offset) : '0;
    assign bus.m_readM   = (state_q == ICACHE_FILL);
    assign bus.m_address = {fill_line_q, {OFFSET_W{1'b0}}};

`ifdef ICACHE_STATS_EN
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit && hit_cnt != {CNT_W{1'b1}}) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (load_fill && miss_cnt != {CNT_W{1'b1}}) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed, table-driven bench for icache with NUM_LINES=8.
module tb_icache;

    logic clk;
    logic rst_n;

    icache_if bus();

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    icache #(.NUM_LINES(8)) dut (
        .Clk        (clk),
        .Reset_N    (rst_n),
        .bus        (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic        exp_rdy;
        logic [15:0] exp_dat;
    } vec_t;

    vec_t vecs[6];

    localparam logic [63:0] L1  = 64'h4444_3333_2222_1111;
    localparam logic [63:0] LA  = 64'hAAA3_AAA2_AAA1_AAA0;
    localparam logic [63:0] LB  = 64'hBBB3_BBB2_BBB1_BBB0;
    localparam logic [63:0] L10 = 64'h1003_1002_1001_1000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.i_readM   = 1'b0;
        bus.i_address = '0;
        bus.m_valid   = 1'b0;
        bus.m_data    = '0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Presents a missing address, waits for the fill request, returns the line in
    // cycle k = wait_n, then checks the hit in cycle k+1 (left there, not stepped).
    task automatic do_fill(input string tag, input logic [15:0] addr,
                           input logic [63:0] line, input int wait_n);
        logic [63:0] ln;
        int          off;
        ln  = line;
        off = int'(addr[1:0]);
        bus.i_readM   = 1'b1;
        bus.i_address = addr;
        #2;
        chk({tag, " miss"}, 64'(bus.i_ready), 64'd0);
        tick();
        #2;
        chk({tag, " m_readM"}, 64'(bus.m_readM), 64'd1);
        chk({tag, " m_address"}, 64'(bus.m_address), 64'({addr[15:2], 2'b00}));
        chk({tag, " stall"}, 64'(bus.i_ready), 64'd0);
        repeat (wait_n - 1) tick();
        bus.m_valid = 1'b1;
        bus.m_data  = line;
        tick();
        bus.m_valid = 1'b0;
        bus.m_data  = '0;
        #2;
        chk({tag, " hit after fill"}, 64'(bus.i_ready), 64'd1);
        chk({tag, " data after fill"}, 64'(bus.i_data), 64'(ln[off*16 +: 16]));
        chk({tag, " m_readM low"}, 64'(bus.m_readM), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 16'h0004, 1'b1, 16'h1111};
        vecs[1] = '{1'b1, 16'h0005, 1'b1, 16'h2222};
        vecs[2] = '{1'b1, 16'h0006, 1'b1, 16'h3333};
        vecs[3] = '{1'b1, 16'h0007, 1'b1, 16'h4444};
        vecs[4] = '{1'b0, 16'h0004, 1'b0, 16'h0000};
        vecs[5] = '{1'b1, 16'h0007, 1'b1, 16'h4444};

        // Reset state
        do_reset();
        #2;
        chk("reset m_readM", 64'(bus.m_readM), 64'd0);
        chk("reset m_address", 64'(bus.m_address), 64'd0);
        chk("reset i_ready", 64'(bus.i_ready), 64'd0);
        chk("reset i_data", 64'(bus.i_data), 64'd0);
        tick();

        // First miss: 0x0005, line returned 3 cycles later
        do_fill("fill5", 16'h0005, L1, 3);
        tick();

        // Sequential hits over the installed line
        for (int i = 0; i < 6; i++) begin
            bus.i_readM   = vecs[i].rd;
            bus.i_address = vecs[i].addr;
            #2;
            chk($sformatf("vec%0d i_ready", i), 64'(bus.i_ready), 64'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d i_data", i), 64'(bus.i_data), 64'(vecs[i].exp_dat));
            chk($sformatf("vec%0d m_readM", i), 64'(bus.m_readM), 64'd0);
            tick();
        end

        // Conflict on index 0: tags 0 and 1 evict each other; back-to-back fills
        do_fill("conf0", 16'h0000, LA, 1);
        do_fill("conf20", 16'h0020, LB, 2);
        do_fill("conf0again", 16'h0000, LA, 1);
        bus.i_address = 16'h0004;
        #1;
        chk("index1 survives i_ready", 64'(bus.i_ready), 64'd1);
        chk("index1 survives i_data", 64'(bus.i_data), 64'h1111);
        tick();

        // Reset pulsed during a fill abandons it
        do_reset();
        bus.i_readM   = 1'b1;
        bus.i_address = 16'h0004;
        tick();
        #2;
        chk("pre-reset m_readM", 64'(bus.m_readM), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset m_readM", 64'(bus.m_readM), 64'd0);
        chk("async reset m_address", 64'(bus.m_address), 64'd0);
        #1;
        rst_n = 1'b1;
        bus.i_readM = 1'b0;
        tick();
        bus.m_valid = 1'b1;
        bus.m_data  = L1;
        tick();
        bus.m_valid = 1'b0;
        bus.m_data  = '0;
        #2;
        chk("stray m_valid m_readM", 64'(bus.m_readM), 64'd0);
        bus.i_readM   = 1'b1;
        bus.i_address = 16'h0004;
        #1;
        chk("abandoned line misses", 64'(bus.i_ready), 64'd0);
        tick();

        // Address changes mid-fill: the original line still lands
        #2;
        chk("chg m_readM", 64'(bus.m_readM), 64'd1);
        bus.i_address = 16'h0010;
        #1;
        chk("chg stall", 64'(bus.i_ready), 64'd0);
        chk("chg m_address held", 64'(bus.m_address), 64'h0004);
        tick();
        bus.m_valid = 1'b1;
        bus.m_data  = L1;
        tick();
        bus.m_valid = 1'b0;
        bus.m_data  = '0;
        #2;
        chk("chg new addr misses", 64'(bus.i_ready), 64'd0);
        chk("chg idle m_readM", 64'(bus.m_readM), 64'd0);
        tick();
        #2;
        chk("chg second fill m_readM", 64'(bus.m_readM), 64'd1);
        chk("chg second fill m_address", 64'(bus.m_address), 64'h0010);
        bus.m_valid = 1'b1;
        bus.m_data  = L10;
        tick();
        bus.m_valid = 1'b0;
        bus.m_data  = '0;
        #2;
        chk("chg 0x10 hit", 64'(bus.i_ready), 64'd1);
        chk("chg 0x10 data", 64'(bus.i_data), 64'h1000);
        bus.i_address = 16'h0005;
        #1;
        chk("chg 0x04 line installed", 64'(bus.i_ready), 64'd1);
        chk("chg 0x05 data", 64'(bus.i_data), 64'h2222);
        tick();

`ifdef ICACHE_STATS_EN
        do_reset();
        #2;
        chk("stats reset hit", 64'(hit_count), 64'd0);
        chk("stats reset miss", 64'(miss_count), 64'd0);
        tick();
        do_fill("stats", 16'h0004, L1, 2);
        repeat (5) tick();
        bus.i_readM = 1'b0;
        #1;
        chk("stats hit_count", 64'(hit_count), 64'd5);
        chk("stats miss_count", 64'(miss_count), 64'd1);
        force dut.hit_cnt = 16'hFFFF;
        #1;
        release dut.hit_cnt;
        bus.i_readM   = 1'b1;
        bus.i_address = 16'h0006;
        tick();
        bus.i_readM = 1'b0;
        #1;
        chk("stats hit saturate", 64'(hit_count), 64'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipelined CPU's instruction-memory port and a slow line-based instruction memory. On a hit it returns the addressed 16-bit word in the same cycle. On a miss it fetches the whole 4-word line from memory and stalls the CPU fetch (`i_ready` low) until the line is installed.

## Interface
- `NUM_LINES`, default 8, number of cache lines; power of two, range 2–64.
- `LINE_WORDS`, fixed at 4, words per line; not overridable.
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset_N`  in  1  reset; asynchronous, active-low.
- `i_readM`  in  1  CPU fetch request.
- `i_address`  in  16  CPU word address.
- `i_data`  out  16  fetched word; valid only while `i_ready`=1, otherwise 16'h0000.
- `i_ready`  out  1  hit indication; the CPU stalls IF while `i_readM`=1 and `i_ready`=0.
- `m_readM`  out  1  line read request to memory; held high for the whole fill.
- `m_address`  out  16  line-aligned address, low 2 bits always 0.
- `m_data`  in  64  returned line; word 0 in bits [15:0], word 3 in bits [63:48].
- `m_valid`  in  1  one-cycle pulse; `m_data` is valid in that cycle.
- `hit_count`, `miss_count`  out  16 each  present only with `ICACHE_STATS_EN` (see Configuration).

## Operation
- Address split:
  - offset = `i_address`[1:0].
  - index = next log2(`NUM_LINES`) bits.
  - tag = remaining upper bits.
- Per-line state: valid bit, tag, 64-bit data.
- FSM has two states, IDLE and FILL.
- IDLE:
  - hit = `i_readM` & valid[index] & (tag[index] == addr tag).
  - `i_ready` = hit, combinational. `i_data` = the selected word.
  - A miss (`i_readM` & !hit) registers the line address {tag, index, 2'b00} into `m_address` and moves to FILL.
- FILL:
  - `m_readM`=1, `m_address` stable, `i_ready`=0.
  - On `m_valid`: write data, tag and valid=1 into the line at the registered index, then return to IDLE.
- The fill is never aborted. If `i_readM` drops or `i_address` changes during FILL, the line is still installed, and lookup resumes on the current inputs in IDLE.
- `m_valid` is ignored outside FILL.
- A replaced line is simply overwritten; there is no write-back because the cache is read-only.
- Reset (asynchronous, any state, including mid-fill):
  - state=IDLE, all valid bits=0.
  - `m_readM`=0, `m_address`=0, counters=0.
  - A fill that was in progress is abandoned; its line stays invalid.
  - Tag and data arrays need no reset.

## Timing
- Hit: 0-cycle latency. `i_data` and `i_ready` are combinational from `i_address` in the same cycle.
- Miss detected in cycle 0:
  - `m_readM` rises at the edge ending cycle 0.
  - If `m_valid` arrives in cycle k (k≥1), the line is written at the edge ending cycle k.
  - In cycle k+1 the state is IDLE and the same address hits.
  - Minimum miss penalty is 2 cycles.
- `m_readM` falls at the same edge that installs the line.
- If the CPU presents a new miss in cycle k+1, the next FILL starts with no idle gap.

## Configuration
- `ICACHE_STATS_EN` defined:
  - 16-bit `hit_count` increments each IDLE cycle with `i_readM`=1 and hit.
  - 16-bit `miss_count` increments on each IDLE→FILL transition.
  - Both counters saturate at 16'hFFFF and reset to 0.
- `ICACHE_STATS_EN` undefined: neither port nor the counter logic exists.

## Structure
- Shared constants file holds:
  - `WORD_SIZE`.
  - `ICACHE_LINE_WORDS`=4.
  - FSM state encodings `ICACHE_IDLE`=1'b0, `ICACHE_FILL`=1'b1.
- One sub-module, `icache_line_store`:
  - Valid/tag/data arrays.
  - Asynchronous read port indexed by index.
  - Synchronous write port with write enable.
  - Valid-clear on `Reset_N`.
- The `icache` top holds the FSM, address split, hit compare, word mux and counters.

## Test plan
- After reset, `i_readM`=1, `i_address`=16'h0005 → `i_ready`=0; next cycle `m_readM`=1, `m_address`=16'h0004; `m_valid` after 3 cycles with `m_data`=64'h4444_3333_2222_1111 → following cycle `i_ready`=1, `i_data`=16'h2222.
- Sequential fetch of 16'h0004–16'h0007 after that fill → 4 consecutive hits returning 16'h1111, 16'h2222, 16'h3333, 16'h4444, with `m_readM`=0 throughout.
- Conflict: with `NUM_LINES`=8, fetch 16'h0000 then 16'h0020 (same index, different tag) → second access misses; refetching 16'h0000 misses again.
- Address changed to 16'h0010 mid-FILL for line 16'h0004 → line 16'h0004 still installed; 16'h0010 then misses and starts its own fill on the next edge.
- `Reset_N` pulsed low during FILL, then `m_valid` arrives → `m_readM`=0 immediately; `m_valid` ignored; 16'h0004 misses afterwards.
- With `ICACHE_STATS_EN`: 1 miss followed by 5 hit cycles → `miss_count`=1, `hit_count`=5. Forcing `hit_count` to 16'hFFFF and applying a further hit leaves it at 16'hFFFF.
